uart_prog_loader: RTL and testbench

- Receives a program image over the SoC UART RX pin while the core is held idle.
- Packs incoming bytes big-endian, first byte to [31:24], into 32-bit instruction words.
- Writes each word into the instruction ROM write port at auto-incrementing word addresses.
- Sits between the `uart_rx` pad and the instruction ROM inside the SoC top. Software releases the core by pulsing reset after the load.

---
 rtl/uart_prog_loader_pkg.sv | 26 ++
 rtl/uart_prog_loader_rx_byte.sv | 119 +++++++++++
 rtl/uart_prog_loader.sv | 123 ++++++++++++
 tb/tb_uart_prog_loader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
// Optional even-parity support is selected with UART_LOADER_PARITY_EN.
package uart_prog_loader_pkg;

    localparam int WORD_W = 32;
    localparam int LANE_W = 8;

    // Byte count value -> lane; first byte received lands in the MSB lane
    localparam logic [1:0] LANE_B3 = 2'd0;
    localparam logic [1:0] LANE_B2 = 2'd1;
    localparam logic [1:0] LANE_B1 = 2'd2;
    localparam logic [1:0] LANE_B0 = 2'd3;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_prog_loader_rx_byte.sv
// UART byte receiver: 2-flop synchronizer, start/data/stop FSM, byte strobes.
// With UART_LOADER_PARITY_EN an even parity bit precedes the stop bit.
module uart_rx_byte
    import uart_prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic       start_o,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       frame_err_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             sync1_q, sync2_q, prev_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             fall, tick, par_err;

    assign fall = prev_q & ~sync2_q;
    assign tick = (state_q == RX_START) ? (cnt_q == HALF)
                                        : (state_q != RX_IDLE && cnt_q == FULL);
    assign byte_o = shift_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RX_IDLE:  if (fall) state_d = RX_START;
            RX_START: if (tick) state_d = sync2_q ? RX_IDLE : RX_DATA;
            RX_DATA: begin
                if (tick && bit_q == 3'd7) begin
`ifdef UART_LOADER_PARITY_EN
                    state_d = RX_PARITY;
`else
                    state_d = RX_STOP;
`endif
                end
            end
`ifdef UART_LOADER_PARITY_EN
            RX_PARITY: if (tick) state_d = RX_STOP;
`endif
            RX_STOP:  if (tick) state_d = RX_IDLE;
            default:  state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        start_o      = 1'b0;
        byte_valid_o = 1'b0;
        frame_err_o  = 1'b0;
        unique case (state_q)
            RX_IDLE: start_o = fall;
            RX_STOP: begin
                byte_valid_o = tick & sync2_q & ~par_err;
                frame_err_o  = tick & (~sync2_q | par_err);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (state_q == RX_IDLE || tick) cnt_q <= '0;
            else                            cnt_q <= cnt_q + 1'b1;
            if (state_q == RX_START) begin
                bit_q <= '0;
            end else if (state_q == RX_DATA && tick) begin
                bit_q   <= bit_q + 3'd1;
                shift_q <= {sync2_q, shift_q[7:1]};
            end
        end
    end

`ifdef UART_LOADER_PARITY_EN
    logic par_q, par_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q     <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            if (state_q == RX_START)             par_q <= 1'b0;
            else if (state_q == RX_DATA && tick) par_q <= par_q ^ sync2_q;
            if (state_q == RX_PARITY && tick)    par_err_q <= par_q ^ sync2_q;
        end
    end

    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: rtl/uart_prog_loader.sv
// Loads a big-endian program image from UART into the instruction ROM.
// Even parity framing is enabled by defining UART_LOADER_PARITY_EN.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD         = 9600,
    parameter int ADDR_W       = 12,
    parameter int IDLE_TIMEOUT = 4 * clks_per_bit(CLK_FREQ, BAUD) * 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uart_rx,
    output logic              rom_we_o,
    output logic [ADDR_W-1:0] rom_waddr_o,
    output logic [WORD_W-1:0] rom_wdata_o,
    output logic              load_busy_o,
    output logic              load_done_o,
    output logic              frame_err_o,
    output logic              addr_wrap_o
);

    localparam int CPB  = clks_per_bit(CLK_FREQ, BAUD);
    localparam int TO_W = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(IDLE_TIMEOUT - 1);

    logic              start, byte_valid;
    logic [7:0]        rx_byte;
    logic              expire, last_byte;

    logic [1:0]        cnt_q, cnt_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wrap_q, wrap_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [TO_W-1:0]   to_q, to_d;

    uart_rx_byte #(
        .CLKS_PER_BIT(CPB)
    ) u_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_i        (uart_rx),
        .start_o     (start),
        .byte_valid_o(byte_valid),
        .byte_o      (rx_byte),
        .frame_err_o (frame_err_o)
    );

    assign expire    = busy_q && (to_q == TO_LAST);
    assign last_byte = byte_valid && (cnt_q == LANE_B0);

    always_comb begin
        word_d = word_q;
        if (byte_valid) begin
            unique case (cnt_q)
                LANE_B3: word_d[31:24] = rx_byte;
                LANE_B2: word_d[23:16] = rx_byte;
                LANE_B1: word_d[15:8]  = rx_byte;
                LANE_B0: word_d[7:0]   = rx_byte;
            endcase
        end
    end

    always_comb begin
        we_d    = last_byte;
        wdata_d = last_byte ? word_d : wdata_q;
        addr_d  = we_q ? addr_q + 1'b1 : addr_q;
        wrap_d  = wrap_q | (we_q & (&addr_q));
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        to_d    = to_q;
        done_d  = 1'b0;
        // A start bit coinciding with expiry keeps the load open
        if (start) begin
            busy_d = 1'b1;
            to_d   = '0;
        end else if (expire) begin
            busy_d = 1'b0;
            to_d   = '0;
            done_d = 1'b1;
        end else if (busy_q) begin
            to_d = to_q + 1'b1;
        end
        if (expire && !start)  cnt_d = '0;
        else if (byte_valid)   cnt_d = cnt_q + 2'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            word_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            to_q    <= '0;
        end else begin
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wrap_q  <= wrap_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            to_q    <= to_d;
        end
    end

    assign rom_we_o    = we_q;
    assign rom_waddr_o = addr_q;
    assign rom_wdata_o = wdata_q;
    assign load_busy_o = busy_q;
    assign load_done_o = done_q;
    assign addr_wrap_o = wrap_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed scoreboard bench for uart_prog_loader at a reduced bit rate.
`timescale 1ns/1ps
module tb_uart_prog_loader;

    localparam int CLK_FREQ = 1600000;
    localparam int BAUD     = 100000;
    localparam int CPB      = 16;
    localparam int ADDR_W   = 3;
    localparam int TO       = 4 * CPB * 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              uart_rx = 1'b1;
    logic              rom_we_o;
    logic [ADDR_W-1:0] rom_waddr_o;
    logic [31:0]       rom_wdata_o;
    logic              load_busy_o, load_done_o, frame_err_o, addr_wrap_o;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_we     = 0;
    int   n_done   = 0;
    int   n_fe     = 0;
    logic prev_we  = 1'b0;

    always #5 clk = ~clk;

    uart_prog_loader #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rx    (uart_rx),
        .rom_we_o   (rom_we_o),
        .rom_waddr_o(rom_waddr_o),
        .rom_wdata_o(rom_wdata_o),
        .load_busy_o(load_busy_o),
        .load_done_o(load_done_o),
        .frame_err_o(frame_err_o),
        .addr_wrap_o(addr_wrap_o)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rom_we_o) begin
            n_we++;
            check("we_one_cycle", prev_we, 0);
            check("strobe_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("waddr", rom_waddr_o, e.a);
                check("wdata", rom_wdata_o, e.d);
            end
        end
        if (load_done_o) n_done++;
        if (frame_err_o) n_fe++;
        prev_we = rom_we_o;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            cyc(CPB);
        end
`ifdef UART_LOADER_PARITY_EN
        uart_rx = ^b;
        cyc(CPB);
`endif
        uart_rx = stop;
        cyc(CPB);
        uart_rx = 1'b1;
        if (!stop) cyc(2 * CPB);
    endtask

    task automatic send_word(input logic [ADDR_W-1:0] a, input logic [31:0] w);
        sb.push_back('{a: a, d: w});
        send_byte(w[31:24], 1'b1);
        send_byte(w[23:16], 1'b1);
        send_byte(w[15:8], 1'b1);
        send_byte(w[7:0], 1'b1);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 400 && sb.size() != 0; i++) cyc(1);
        check(tag, sb.size(), 0);
    endtask

    task automatic do_reset(input string tag);
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        cyc(3);
        check(tag, {rom_we_o, rom_waddr_o, rom_wdata_o, load_busy_o,
                    load_done_o, frame_err_o, addr_wrap_o}, 0);
        sb.delete();
        rst_n = 1'b1;
        cyc(4);
    endtask

    int we0, done0, fe0;

    initial begin
        do_reset("reset_outs");

        // single word
        we0 = n_we;
        send_word(0, 32'h00100093);
        wait_drain("t1_drain");
        check("t1_busy", load_busy_o, 1);
        check("t1_strobes", n_we - we0, 1);

        // four words then idle timeout
        do_reset("reset_t2");
        we0 = n_we;
        done0 = n_done;
        send_word(0, 32'h00100093);
        send_word(1, 32'h00200113);
        send_word(2, 32'h001080B3);
        send_word(3, 32'hFE208EE3);
        wait_drain("t2_drain");
        check("t2_strobes", n_we - we0, 4);
        check("t2_busy_before", load_busy_o, 1);
        cyc(TO + 4 * CPB);
        check("t2_done", n_done - done0, 1);
        check("t2_busy_after", load_busy_o, 0);

        // short low glitch between bytes
        do_reset("reset_t3");
        we0 = n_we;
        fe0 = n_fe;
        sb.push_back('{a: 0, d: 32'h12345678});
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        uart_rx = 1'b0;
        cyc(CPB / 2 - 3);
        uart_rx = 1'b1;
        cyc(3 * CPB);
        check("t3_no_strobe", n_we - we0, 0);
        check("t3_no_fe", n_fe - fe0, 0);
        send_byte(8'h56, 1'b1);
        send_byte(8'h78, 1'b1);
        wait_drain("t3_drain");
        check("t3_strobes", n_we - we0, 1);

        // framing error then a good word
        do_reset("reset_t4");
        we0 = n_we;
        fe0 = n_fe;
        send_byte(8'h55, 1'b0);
        check("t4_fe", n_fe - fe0, 1);
        check("t4_no_strobe", n_we - we0, 0);
        send_word(0, 32'hDEADBEEF);
        wait_drain("t4_drain");

        // partial word dropped by timeout, next load appends
        done0 = n_done;
        send_byte(8'hA1, 1'b1);
        send_byte(8'hA2, 1'b1);
        cyc(TO + 4 * CPB);
        check("t5_done", n_done - done0, 1);
        check("t5_busy", load_busy_o, 0);
        send_word(1, 32'h11223344);
        wait_drain("t5_drain");

        // reset in the middle of the third byte
        do_reset("reset_t6");
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        uart_rx = 1'b0;
        cyc(CPB);
        uart_rx = 1'b1;
        cyc(CPB);
        uart_rx = 1'b0;
        cyc(CPB / 2);
        do_reset("t6_mid_reset");
        cyc(4 * CPB);
        we0 = n_we;
        send_word(0, 32'hCAFEF00D);
        wait_drain("t6_drain");
        check("t6_strobes", n_we - we0, 1);
        check("t6_no_wrap", addr_wrap_o, 0);

        // address wrap
        do_reset("reset_t7");
        for (int k = 0; k < 7; k++) send_word(3'(k), 32'h10000000 + k);
        wait_drain("t7_drain_a");
        check("t7_wrap_clear", addr_wrap_o, 0);
        send_word(7, 32'h20000007);
        send_word(0, 32'h30000000);
        wait_drain("t7_drain_b");
        check("t7_wrap_set", addr_wrap_o, 1);

        cyc(10);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
